// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: PLL reset pulse, lock qualification, SDRAM release, then system release.
// Define RESET_SEQ_RETRY_EN to re-pulse the PLLs when lock does not arrive within LOCK_TIMEOUT cycles.
module reset_sequencer #(
    parameter int STABLE_CYCLES  = 27000,
    parameter int LOCK_TIMEOUT   = 2700000,
    parameter int PLL_RST_CYCLES = 270,
    parameter int SYS_DELAY      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lock_135,
    input  logic       lock_sdram,
    input  logic       sdram_init_done,
    output logic       pll_rst,
    output logic       sdram_rst_n,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [3:0] retry_count
);

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LAST     = CNT_W'(SYS_DELAY - 1);

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_SDRAM     = 3'd3,
        ST_SYSDLY    = 3'd4,
        ST_RUN       = 3'd5
    } state_t;

    logic [1:0]       rst_sync_r;
    logic             rst_int_n_s;
    logic [1:0]       lock_135_sync_r;
    logic [1:0]       lock_sdram_sync_r;
    logic             locks_ok_s;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             pll_rst_s;
    logic             sdram_rst_n_s;
    logic             sys_rst_n_s;
    logic             ready_s;
    logic             pll_rst_r;
    logic             sdram_rst_n_r;
    logic             sys_rst_n_r;
    logic             ready_r;
`ifdef RESET_SEQ_RETRY_EN
    logic [3:0]       retry_r;
    logic [3:0]       retry_s;
`endif

    // Reset bridge: asserts asynchronously, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // Two-flop synchronizers for the asynchronous PLL lock indicators.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            lock_135_sync_r   <= 2'b00;
            lock_sdram_sync_r <= 2'b00;
        end else begin
            lock_135_sync_r   <= {lock_135_sync_r[0], lock_135};
            lock_sdram_sync_r <= {lock_sdram_sync_r[0], lock_sdram};
        end
    end

    assign locks_ok_s = lock_135_sync_r[1] & lock_sdram_sync_r[1];

    // State, shared counter, retry count and registered outputs.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r       <= ST_PLLRST;
            cnt_r         <= CNT_ZERO;
            pll_rst_r     <= 1'b1;
            sdram_rst_n_r <= 1'b0;
            sys_rst_n_r   <= 1'b0;
            ready_r       <= 1'b0;
`ifdef RESET_SEQ_RETRY_EN
            retry_r       <= 4'd0;
`endif
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            pll_rst_r     <= pll_rst_s;
            sdram_rst_n_r <= sdram_rst_n_s;
            sys_rst_n_r   <= sys_rst_n_s;
            ready_r       <= ready_s;
`ifdef RESET_SEQ_RETRY_EN
            retry_r       <= retry_s;
`endif
        end
    end

    // Next-state logic; lock loss is tested before any timer expiry.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_ONE;
`ifdef RESET_SEQ_RETRY_EN
        retry_s = retry_r;
`endif
        case (state_r)
            ST_PLLRST: begin
                if (cnt_r == PLL_LAST) begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_PLLRST;
                end
            end
            ST_WAIT_LOCK: begin
                if (locks_ok_s) begin
                    state_s = ST_STABLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == TIMEOUT_LAST) begin
`ifdef RESET_SEQ_RETRY_EN
                    state_s = ST_PLLRST;
                    cnt_s   = CNT_ZERO;
                    if (retry_r != 4'd15) begin
                        retry_s = retry_r + 4'd1;
                    end else begin
                        retry_s = retry_r;
                    end
`else
                    // Without retry the counter parks at the timeout instead of wrapping.
                    cnt_s = cnt_r;
`endif
                end else begin
                    state_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!locks_ok_s) begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == STABLE_LAST) begin
                    state_s = ST_SDRAM;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_STABLE;
                end
            end
            ST_SDRAM: begin
                if (!locks_ok_s) begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else if (sdram_init_done) begin
                    state_s = ST_SYSDLY;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_SDRAM;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_SYSDLY: begin
                if (!locks_ok_s) begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == SYS_LAST) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_SYSDLY;
                end
            end
            ST_RUN: begin
                cnt_s = CNT_ZERO;
                if (!locks_ok_s) begin
                    state_s = ST_WAIT_LOCK;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_PLLRST;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode of the upcoming state so registered outputs line up with state_r.
    always_comb begin
        pll_rst_s     = 1'b0;
        sdram_rst_n_s = 1'b0;
        sys_rst_n_s   = 1'b0;
        ready_s       = 1'b0;
        case (state_s)
            ST_PLLRST: begin
                pll_rst_s = 1'b1;
            end
            ST_SDRAM, ST_SYSDLY: begin
                sdram_rst_n_s = 1'b1;
            end
            ST_RUN: begin
                sdram_rst_n_s = 1'b1;
                sys_rst_n_s   = 1'b1;
                ready_s       = 1'b1;
            end
            default: begin
                pll_rst_s     = 1'b0;
                sdram_rst_n_s = 1'b0;
            end
        endcase
    end

    assign pll_rst     = pll_rst_r;
    assign sdram_rst_n = sdram_rst_n_r;
    assign sys_rst_n   = sys_rst_n_r;
    assign ready       = ready_r;
`ifdef RESET_SEQ_RETRY_EN
    assign retry_count = retry_r;
`else
    assign retry_count = 4'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table, hand-written corner sequences, random run vs model.
module tb_reset_sequencer;

    localparam int STABLE_C = 8;
    localparam int TIMEOUT_C = 20;
    localparam int PLLRST_C = 4;
    localparam int SYSDLY_C = 3;

    localparam int M_PLLRST = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_SDRAM  = 3;
    localparam int M_SYSDLY = 4;
    localparam int M_RUN    = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock_135;
    logic       lock_sdram;
    logic       sdram_init_done;
    logic       pll_rst;
    logic       sdram_rst_n;
    logic       sys_rst_n;
    logic       ready;
    logic [3:0] retry_count;

    int tests = 0;
    int fails = 0;

    // Reference model: stage number, cycles spent in stage, lock delay line, release delay.
    int m_stage, m_dwell, m_rel, m_retry;
    bit m_d1, m_d2;

    typedef struct {
        logic       rst;
        logic       l135;
        logic       lsd;
        logic       init;
        int         cycles;
        logic [7:0] exp;   // {pll_rst, sdram_rst_n, sys_rst_n, ready, retry_count}
    } vec_t;

    vec_t tbl[26];

    always #5 clk = ~clk;

    reset_sequencer #(
        .STABLE_CYCLES (STABLE_C),
        .LOCK_TIMEOUT  (TIMEOUT_C),
        .PLL_RST_CYCLES(PLLRST_C),
        .SYS_DELAY     (SYSDLY_C)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lock_135       (lock_135),
        .lock_sdram     (lock_sdram),
        .sdram_init_done(sdram_init_done),
        .pll_rst        (pll_rst),
        .sdram_rst_n    (sdram_rst_n),
        .sys_rst_n      (sys_rst_n),
        .ready          (ready),
        .retry_count    (retry_count)
    );

    function automatic logic [7:0] dut_out();
        return {pll_rst, sdram_rst_n, sys_rst_n, ready, retry_count};
    endfunction

    function automatic logic [7:0] m_out();
        return {m_stage == M_PLLRST, m_stage >= M_SDRAM, m_stage == M_RUN, m_stage == M_RUN, 4'(m_retry)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_stage = M_PLLRST;
        m_dwell = 0;
        m_rel   = 0;
        m_retry = 0;
        m_d1    = 1'b0;
        m_d2    = 1'b0;
    endtask

    task automatic m_go(input int s);
        m_stage = s;
        m_dwell = 0;
    endtask

    task automatic m_step();
        bit ok;
        ok   = m_d2;
        m_d2 = m_d1;
        m_d1 = lock_135 & lock_sdram;
        m_dwell++;
        if (m_stage == M_PLLRST) begin
            if (m_dwell == PLLRST_C) m_go(M_WAIT);
        end else if (m_stage == M_WAIT) begin
            if (ok) m_go(M_STABLE);
`ifdef RESET_SEQ_RETRY_EN
            else if (m_dwell == TIMEOUT_C) begin
                m_go(M_PLLRST);
                if (m_retry < 15) m_retry++;
            end
`endif
        end else if (!ok) begin
            m_go(M_WAIT);
        end else if (m_stage == M_STABLE && m_dwell == STABLE_C) begin
            m_go(M_SDRAM);
        end else if (m_stage == M_SDRAM && sdram_init_done) begin
            m_go(M_SYSDLY);
        end else if (m_stage == M_SYSDLY && m_dwell == SYSDLY_C) begin
            m_go(M_RUN);
        end
    endtask

    // One clock: model advances on the edge, DUT is compared on the falling edge.
    task automatic tick();
        logic bad;
        @(posedge clk);
        if (!rst_n) m_reset();
        else if (m_rel < 2) m_rel++;
        else m_step();
        @(negedge clk);
        check("model", dut_out(), m_out());
        bad = (sys_rst_n && !sdram_rst_n) || (pll_rst && (sdram_rst_n || sys_rst_n));
        check("reset_order", {7'd0, bad}, 8'd0);
    endtask

    task automatic set_in(input logic r, input logic a, input logic b, input logic i);
        if (!r) m_reset();
        rst_n           = r;
        lock_135        = a;
        lock_sdram      = b;
        sdram_init_done = i;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b1;
        lock_135 = 1'b1;
        lock_sdram = 1'b1;
        sdram_init_done = 1'b1;
        m_reset();

        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1,   3, 8'b1000_0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1,   2, 8'b1000_0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1,   3, 8'b1000_0000};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1,   1, 8'b0000_0000};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1,   8, 8'b0000_0000};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1,   1, 8'b0100_0000};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1,   3, 8'b0100_0000};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1,   1, 8'b0111_0000};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1,   2, 8'b0111_0000};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1,   1, 8'b0000_0000};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1,   5, 8'b0000_0000};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1,  10, 8'b0000_0000};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1,   1, 8'b0100_0000};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1,   3, 8'b0100_0000};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1,   1, 8'b0111_0000};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0,   2, 8'b1000_0000};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0,  15, 8'b0100_0000};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 100, 8'b0100_0000};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1,   3, 8'b0100_0000};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b1,   1, 8'b0111_0000};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1,   2, 8'b1000_0000};
        tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b1,  12, 8'b0000_0000};
        tbl[22] = '{1'b1, 1'b0, 1'b1, 1'b1,   1, 8'b0000_0000};
        tbl[23] = '{1'b1, 1'b1, 1'b1, 1'b1,   2, 8'b0000_0000};
        tbl[24] = '{1'b1, 1'b1, 1'b1, 1'b1,   8, 8'b0000_0000};
        tbl[25] = '{1'b1, 1'b1, 1'b1, 1'b1,   1, 8'b0100_0000};

        #1;
        for (int i = 0; i < 26; i++) begin
            set_in(tbl[i].rst, tbl[i].l135, tbl[i].lsd, tbl[i].init);
            for (int c = 0; c < tbl[i].cycles; c++) tick();
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Asynchronous reset in the middle of SYSDLY.
        tick();
        check("h1_sysdly", dut_out(), 8'b0100_0000);
        #2;
        set_in(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        check("h1_async_reset", dut_out(), 8'b1000_0000);

        // Locks never arrive after reset release.
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        check("h2_pll_pulse", dut_out(), 8'b1000_0000);
        tick();
        check("h2_pll_end", dut_out(), 8'b0000_0000);
`ifdef RESET_SEQ_RETRY_EN
        repeat (20) tick();
        check("h2_retry1", dut_out(), 8'b1000_0001);
        repeat (400) tick();
        check("h2_retry_sat", {4'd0, retry_count}, 8'd15);
`else
        seen = 1'b0;
        repeat (200) begin
            tick();
            if (pll_rst) seen = 1'b1;
        end
        check("h2_no_repulse", {7'd0, seen}, 8'd0);
        check("h2_retry_zero", {4'd0, retry_count}, 8'd0);
`endif

        // Randomized run against the model.
        set_in(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        for (int n = 0; n < 3000; n++) begin
            logic a, b, i;
            a = lock_135 ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 3) == 0);
            b = lock_sdram ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 3) == 0);
            i = ($urandom_range(0, 9) == 0) ? ~sdram_init_done : sdram_init_done;
            set_in(($urandom_range(0, 499) != 0), a, b, i);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
